// File: rtl/wb_port_arbiter_if.sv
// Bundle of the write-port arbiter's signals: pipeline writeback, MDU result
// handshake, hazard queries, and the register-file write port.
interface wb_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        pend1;
  logic        pend2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  modport slave (
    input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, q_rs1, q_rs2,
    output mdu_ready, pend1, pend2, WE3, A3, WD3
  );

  modport master (
    output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, q_rs1, q_rs2,
    input  mdu_ready, pend1, pend2, WE3, A3, WD3
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU
// results queue in a FIFO and drain in idle slots, with WAW kill and pend flags.
module wb_port_arbiter #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [4:0]       rd_r   [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;

  logic        wb_act_s;
  logic        head_present_s;
  logic        pop_s;
  logic        ready_s;
  logic        enq_s;
  logic        we_s;
  logic [4:0]  a3_s;
  logic [31:0] wd3_s;
  logic        pend1_s;
  logic        pend2_s;

  // Handshake and pop decisions from registered occupancy.
  always_comb begin
    wb_act_s       = bus.wb_we && (bus.wb_rd != 5'd0);
    head_present_s = (count_r != '0);
    pop_s          = !wb_act_s && head_present_s;
    ready_s        = rst_n && (count_r != FULL_CNT);
    enq_s          = bus.mdu_valid && ready_s && (bus.mdu_rd != 5'd0);
  end

  // Write-port mux: pipeline first, then a valid FIFO head; killed heads stay silent.
  always_comb begin
    we_s  = 1'b0;
    a3_s  = 5'd0;
    wd3_s = 32'd0;
    if (!rst_n) begin
      we_s = 1'b0;
    end else if (wb_act_s) begin
      we_s  = 1'b1;
      a3_s  = bus.wb_rd;
      wd3_s = bus.wb_data;
    end else if (head_present_s && vld_r[head_r]) begin
      we_s  = 1'b1;
      a3_s  = rd_r[head_r];
      wd3_s = data_r[head_r];
    end else begin
      we_s = 1'b0;
    end
  end

  // Pending flags: only live (valid) queued entries count; x0 never pends.
  always_comb begin
    pend1_s = 1'b0;
    pend2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i] && (rd_r[i] == bus.q_rs1)) begin
        pend1_s = 1'b1;
      end else begin
        pend1_s = pend1_s;
      end
      if (vld_r[i] && (rd_r[i] == bus.q_rs2)) begin
        pend2_s = 1'b1;
      end else begin
        pend2_s = pend2_s;
      end
    end
    if (!rst_n || (bus.q_rs1 == 5'd0)) begin
      pend1_s = 1'b0;
    end else begin
      pend1_s = pend1_s;
    end
    if (!rst_n || (bus.q_rs2 == 5'd0)) begin
      pend2_s = 1'b0;
    end else begin
      pend2_s = pend2_s;
    end
  end

  // FIFO state: kill, pop, enqueue and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= 5'd0;
        data_r[i] <= 32'd0;
      end
      vld_r   <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_act_s && vld_r[i] && (rd_r[i] == bus.wb_rd)) begin
          vld_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        vld_r[head_r] <= 1'b0;
        head_r        <= head_r + 1'b1;
      end
      // The tail slot is never the popped slot: a pop needs count>0 and a push needs count<DEPTH.
      if (enq_s) begin
        rd_r[tail_r]   <= bus.mdu_rd;
        data_r[tail_r] <= bus.mdu_data;
        vld_r[tail_r]  <= !(wb_act_s && (bus.mdu_rd == bus.wb_rd));
        tail_r         <= tail_r + 1'b1;
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.WE3       = we_s;
  assign bus.A3        = a3_s;
  assign bus.WD3       = wd3_s;
  assign bus.mdu_ready = ready_s;
  assign bus.pend1     = pend1_s;
  assign bus.pend2     = pend2_s;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// reset sequences, and randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen by the write port, captured on the negedge.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (bus.WE3) rf[bus.A3] <= bus.WD3;
  end

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          v;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic we, input logic [4:0] rd, input logic [31:0] d,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic [4:0] q1, input logic [4:0] q2,
                     input logic e_we, input logic [4:0] e_a3, input logic [31:0] e_wd,
                     input logic e_rdy, input logic e_p1, input logic e_p2);
    vec_t v;
    v = '{we, rd, d, mv, mrd, md, q1, q2, e_we, e_a3, e_wd, e_rdy, e_p1, e_p2};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = d;
    bus.mdu_valid = mv; bus.mdu_rd = mrd; bus.mdu_data = md;
    bus.q_rs1 = q1; bus.q_rs2 = q2;
  endtask

  // Model: compare outputs for current inputs, then advance one clock edge.
  task automatic model_step(input string tag);
    bit          act;
    bit          e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    bit          rdy;
    bit          p1;
    bit          p2;
    ent_t        e;
    act  = bus.wb_we && (bus.wb_rd != 5'd0);
    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0;
    if (act) begin
      e_we = 1'b1; e_a3 = bus.wb_rd; e_wd = bus.wb_data;
    end else if (mq.size() > 0 && mq[0].v) begin
      e_we = 1'b1; e_a3 = mq[0].rd; e_wd = mq[0].data;
    end
    rdy = (mq.size() < DEPTH);
    p1 = 1'b0; p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].v && mq[i].rd == bus.q_rs1 && bus.q_rs1 != 5'd0) p1 = 1'b1;
      if (mq[i].v && mq[i].rd == bus.q_rs2 && bus.q_rs2 != 5'd0) p2 = 1'b1;
    end
    chk({tag, ".WE3"}, {31'd0, bus.WE3}, {31'd0, e_we});
    chk({tag, ".A3"}, {27'd0, bus.A3}, {27'd0, e_a3});
    chk({tag, ".WD3"}, bus.WD3, e_wd);
    chk({tag, ".ready"}, {31'd0, bus.mdu_ready}, {31'd0, rdy});
    chk({tag, ".pend1"}, {31'd0, bus.pend1}, {31'd0, p1});
    chk({tag, ".pend2"}, {31'd0, bus.pend2}, {31'd0, p2});
    if (!act && mq.size() > 0) void'(mq.pop_front());
    if (act) foreach (mq[i]) if (mq[i].rd == bus.wb_rd) mq[i].v = 1'b0;
    if (bus.mdu_valid && rdy && bus.mdu_rd != 5'd0) begin
      e.rd = bus.mdu_rd; e.data = bus.mdu_data; e.v = !(act && bus.mdu_rd == bus.wb_rd);
      mq.push_back(e);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    // Directed sequence from reset (priority, full, kill, same-cycle kill, x0).
    add(1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hA,   5'd5, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0,   5'd5, 5'd0,  1'b1, 5'd7, 32'h77,  1'b1, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd5, 5'd0,  1'b1, 5'd5, 32'hA,   1'b1, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd5, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b1, 5'd1, 32'h101, 5'd0, 5'd0,  1'b1, 5'd9, 32'h90,  1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b1, 5'd2, 32'h102, 5'd0, 5'd0,  1'b1, 5'd9, 32'h90,  1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b1, 5'd3, 32'h103, 5'd0, 5'd0,  1'b1, 5'd9, 32'h90,  1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b1, 5'd4, 32'h104, 5'd0, 5'd0,  1'b1, 5'd9, 32'h90,  1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b1, 5'd6, 32'h106, 5'd4, 5'd1,  1'b1, 5'd9, 32'h90,  1'b0, 1'b1, 1'b1);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd1, 5'd0,  1'b1, 5'd1, 32'h101, 1'b0, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd1, 5'd0,  1'b1, 5'd2, 32'h102, 1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd0, 5'd0,  1'b1, 5'd3, 32'h103, 1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd0, 5'd0,  1'b1, 5'd4, 32'h104, 1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h11,  5'd3, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'h0,   5'd3, 5'd0,  1'b1, 5'd3, 32'h22,  1'b1, 1'b1, 1'b0);
    add(1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'h0,   5'd3, 5'd0,  1'b1, 5'd9, 32'h90,  1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd3, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd3, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd8, 32'h2,  1'b1, 5'd8, 32'h1,   5'd8, 5'd0,  1'b1, 5'd8, 32'h2,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd8, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h55,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 32'hC,  5'd12, 5'd0, 1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
    add(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b1, 5'd12, 32'hC,  1'b1, 1'b1, 1'b0);
    add(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,   5'd12, 5'd0, 1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);

    // Reset with the pipeline trying to write.
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 32'h1234, 1'b1, 5'd3, 32'h1, 5'd7, 5'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.WE3", {31'd0, bus.WE3}, 32'd0);
    chk("rst.A3", {27'd0, bus.A3}, 32'd0);
    chk("rst.WD3", bus.WD3, 32'd0);
    chk("rst.ready", {31'd0, bus.mdu_ready}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", {31'd0, bus.mdu_ready}, 32'd1);
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      drive(tbl[k].wb_we, tbl[k].wb_rd, tbl[k].wb_data, tbl[k].mv, tbl[k].mrd, tbl[k].md,
            tbl[k].q1, tbl[k].q2);
      @(negedge clk);
      chk($sformatf("v%0d.WE3", k), {31'd0, bus.WE3}, {31'd0, tbl[k].e_we});
      chk($sformatf("v%0d.A3", k), {27'd0, bus.A3}, {27'd0, tbl[k].e_a3});
      chk($sformatf("v%0d.WD3", k), bus.WD3, tbl[k].e_wd);
      chk($sformatf("v%0d.ready", k), {31'd0, bus.mdu_ready}, {31'd0, tbl[k].e_rdy});
      chk($sformatf("v%0d.pend1", k), {31'd0, bus.pend1}, {31'd0, tbl[k].e_p1});
      chk($sformatf("v%0d.pend2", k), {31'd0, bus.pend2}, {31'd0, tbl[k].e_p2});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("final.x3", rf[3], 32'h22);
    chk("final.x8", rf[8], 32'h2);
    chk("final.x5", rf[5], 32'hA);
    @(posedge clk); #1;

    // Randomized traffic; small register range makes kills and pends frequent.
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 6)), $urandom,
            ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 6)), $urandom,
            5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
      @(negedge clk);
      model_step($sformatf("rnd%0d", c));
      @(posedge clk); #1;
    end

    // Async reset mid-drain: fill while the pipeline holds the port, then reset.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd9, 32'h9, 1'b1, 5'(c + 1), 32'(c + 32'h40), 5'd1, 5'd2);
      @(negedge clk);
      model_step($sformatf("fill%0d", c));
      @(posedge clk); #1;
    end
    drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.WE3", {31'd0, bus.WE3}, 32'd0);
    chk("mid.ready", {31'd0, bus.mdu_ready}, 32'd0);
    chk("mid.pend1", {31'd0, bus.pend1}, 32'd0);
    chk("mid.pend2", {31'd0, bus.pend2}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      @(negedge clk);
      model_step($sformatf("post%0d", c));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
